// File: rtl/pe_array_conv_sequencer.sv
// Convolution-pass sequencer for the PE array: filter load, line prime, compute and drain,
// with per-PE strobes paced by the input valid/ready stream.
module pe_array_conv_sequencer #(
    parameter int N_PE      = 8,
    parameter int ROW_W     = 10,
    parameter int DRAIN_CYC = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [ROW_W-1:0] i_cfg_row_length,
    input  logic [ROW_W-1:0] i_cfg_n_rows,
    input  logic [2:0]       i_cfg_ksize,
    input  logic [N_PE-1:0]  i_cfg_pe_mask,
    input  logic             i_cfg_nl_en,
    input  logic             i_in_valid,
    output logic             o_in_ready,
    output logic             o_line_buffer_reset,
    output logic [N_PE-1:0]  o_shifting_filter,
    output logic [N_PE-1:0]  o_shifting_line,
    output logic [N_PE-1:0]  o_mac_enable,
    output logic [N_PE-1:0]  o_adder_enable,
    output logic [N_PE-1:0]  o_nl_enable,
    output logic             o_busy,
    output logic             o_done
);
    localparam int CW = 2 * ROW_W;
    localparam int DW = $clog2(DRAIN_CYC + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_CLEAR, S_LOAD_FILTER, S_LOAD_LINES, S_COMPUTE, S_DRAIN, S_DONE
    } state_t;

    state_t           r_state, w_next;
    logic [ROW_W-1:0] r_row_len, r_n_rows, r_col;
    logic [2:0]       r_ksize;
    logic [N_PE-1:0]  r_mask;
    logic             r_nl_en;
    logic [CW-1:0]    r_beat;
    logic [DW-1:0]    r_drain;
    logic             r_in_ready, r_lbr, r_busy, r_done;

    logic [CW-1:0]    w_k, w_row, w_rows, w_target;
    logic             w_cfg_bad, w_beat, w_last_beat, w_adder_ok;
    logic             w_in_lf, w_in_ll, w_in_co;

    // A 3-bit K field cannot exceed 7, so only K=0 needs rejecting on the K side.
    assign w_cfg_bad = (i_cfg_ksize == 3'd0) || (i_cfg_row_length == '0) ||
                       (i_cfg_n_rows < {{(ROW_W-3){1'b0}}, i_cfg_ksize});

    assign w_k    = {{(CW-3){1'b0}}, r_ksize};
    assign w_row  = {{ROW_W{1'b0}}, r_row_len};
    assign w_rows = {{ROW_W{1'b0}}, r_n_rows};

    always_comb begin
        w_target = '0;
        case (r_state)
            S_LOAD_FILTER: w_target = w_k * w_k;
            S_LOAD_LINES:  w_target = (w_k - 1'b1) * w_row;
            S_COMPUTE:     w_target = (w_rows - w_k + 1'b1) * w_row;
            default:       w_target = '0;
        endcase
    end

    assign w_beat      = r_in_ready & i_in_valid;
    assign w_last_beat = w_beat && ((r_beat + 1'b1) == w_target);
    assign w_in_lf     = (r_state == S_LOAD_FILTER);
    assign w_in_ll     = (r_state == S_LOAD_LINES);
    assign w_in_co     = (r_state == S_COMPUTE);
    // col >= K-1, rearranged to avoid underflow
    assign w_adder_ok  = ({1'b0, r_col} + 1'b1) >= {{(ROW_W-2){1'b0}}, r_ksize};

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:        if (i_start) w_next = w_cfg_bad ? S_DONE : S_CLEAR;
            S_CLEAR:       w_next = S_LOAD_FILTER;
            S_LOAD_FILTER: if (w_last_beat) w_next = (r_ksize == 3'd1) ? S_COMPUTE : S_LOAD_LINES;
            S_LOAD_LINES:  if (w_last_beat) w_next = S_COMPUTE;
            S_COMPUTE:     if (w_last_beat) w_next = S_DRAIN;
            S_DRAIN:       if (r_drain == DW'(DRAIN_CYC - 1)) w_next = S_DONE;
            S_DONE:        w_next = S_IDLE;
            default:       w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= S_IDLE;
            r_row_len  <= '0;
            r_n_rows   <= '0;
            r_ksize    <= '0;
            r_mask     <= '0;
            r_nl_en    <= 1'b0;
            r_beat     <= '0;
            r_col      <= '0;
            r_drain    <= '0;
            r_in_ready <= 1'b0;
            r_lbr      <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == S_IDLE && i_start) begin
                r_row_len <= i_cfg_row_length;
                r_n_rows  <= i_cfg_n_rows;
                r_ksize   <= i_cfg_ksize;
                r_mask    <= i_cfg_pe_mask;
                r_nl_en   <= i_cfg_nl_en;
            end
            if (w_last_beat)
                r_beat <= '0;
            else if (w_beat)
                r_beat <= r_beat + 1'b1;
            if (w_in_co) begin
                if (w_beat)
                    r_col <= ((r_col + 1'b1) == r_row_len) ? '0 : r_col + 1'b1;
            end else begin
                r_col <= '0;
            end
            r_drain <= (r_state == S_DRAIN) ? r_drain + 1'b1 : '0;
            // Status outputs are registered from the next state so they align with r_state.
            r_in_ready <= (w_next == S_LOAD_FILTER) || (w_next == S_LOAD_LINES) ||
                          (w_next == S_COMPUTE);
            r_lbr      <= (w_next == S_CLEAR);
            r_busy     <= (w_next != S_IDLE);
            r_done     <= (w_next == S_DONE);
        end
    end

    assign o_in_ready          = r_in_ready;
    assign o_line_buffer_reset = r_lbr;
    assign o_busy              = r_busy;
    assign o_done              = r_done;

    for (genvar g = 0; g < N_PE; g++) begin : g_lane
        assign o_shifting_filter[g] = r_mask[g] & w_beat & w_in_lf;
        assign o_shifting_line[g]   = r_mask[g] & w_beat & (w_in_ll | w_in_co);
        assign o_mac_enable[g]      = r_mask[g] & w_beat & w_in_co;
        assign o_adder_enable[g]    = r_mask[g] & w_beat & w_in_co & w_adder_ok;
        assign o_nl_enable[g]       = r_mask[g] & w_beat & w_in_co & w_adder_ok & r_nl_en;
    end

endmodule

// File: tb/tb_pe_array_conv_sequencer.sv
// Table-driven bench for pe_array_conv_sequencer: each row runs one pass and compares
// per-strobe beat counts, first/last cycles and done timing against hand-computed values.
module tb_pe_array_conv_sequencer;
    logic       clk = 1'b0;
    logic       rst, start, nl_en, in_valid;
    logic [9:0] row_len, n_rows;
    logic [2:0] ksize;
    logic [7:0] mask;
    logic       in_ready, lbr, busy, done;
    logic [7:0] sf, sl, mac, add, nl;

    int checks = 0;
    int passes = 0;

    pe_array_conv_sequencer dut (
        .i_clk(clk), .i_rst(rst), .i_start(start),
        .i_cfg_row_length(row_len), .i_cfg_n_rows(n_rows), .i_cfg_ksize(ksize),
        .i_cfg_pe_mask(mask), .i_cfg_nl_en(nl_en), .i_in_valid(in_valid),
        .o_in_ready(in_ready), .o_line_buffer_reset(lbr),
        .o_shifting_filter(sf), .o_shifting_line(sl), .o_mac_enable(mac),
        .o_adder_enable(add), .o_nl_enable(nl), .o_busy(busy), .o_done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        string name;
        int k, row, rows, msk, nle, stall_at, rst_at, repulse;
        int done_c, done_n, busy_n, lbr_n;
        int sf_n, sf_f, sf_l, sl_n, sl_f, mac_n, mac_f, mac_l, add_n, nl_n;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic run_pass(input vec_t v);
        int done_c = -1, done_n = 0, busy_n = 0, lbr_n = 0;
        int sf_n = 0, sf_f = -1, sf_l = -1, sl_n = 0, sl_f = -1;
        int mac_n = 0, mac_f = -1, mac_l = -1, add_n = 0, nl_n = 0;
        int outside = 0, stall_hits = 0;
        logic [7:0] m;
        logic [7:0] any;
        m = v.msk[7:0];
        for (int c = 0; c < 110; c++) begin
            @(posedge clk); #1;
            start    = (c == 0) || (v.repulse != 0 && (c == 5 || c == 35));
            rst      = (c == v.rst_at);
            in_valid = !(v.stall_at >= 0 && c >= v.stall_at && c < v.stall_at + 3);
            if (c == 5 || c == 35) begin
                ksize = 3'd1; row_len = 10'd2; n_rows = 10'd1; mask = 8'h0F; nl_en = 1'b0;
            end else begin
                ksize = v.k[2:0]; row_len = v.row[9:0]; n_rows = v.rows[9:0];
                mask = m; nl_en = v.nle[0];
            end
            @(negedge clk);
            any = sf | sl | mac | add | nl;
            if ((any & ~m) != 8'h0) outside++;
            if (!in_valid && any != 8'h0) stall_hits++;
            if (done) begin done_n++; if (done_c < 0) done_c = c; end
            if (busy) busy_n++;
            if (lbr) lbr_n++;
            if (sf != 8'h0) begin if (sf == m) sf_n++; if (sf_f < 0) sf_f = c; sf_l = c; end
            if (sl != 8'h0) begin if (sl == m) sl_n++; if (sl_f < 0) sl_f = c; end
            if (mac != 8'h0) begin if (mac == m) mac_n++; if (mac_f < 0) mac_f = c; mac_l = c; end
            if (add != 8'h0 && add == m) add_n++;
            if (nl != 8'h0 && nl == m) nl_n++;
            if (v.rst_at >= 0 && c == v.rst_at + 1)
                check({v.name, " outputs zero after rst"},
                      int'({in_ready, lbr, busy, done, any}), 0);
        end
        rst = 1'b0; start = 1'b0;
        check({v.name, " done cycle"}, done_c, v.done_c);
        check({v.name, " done count"}, done_n, v.done_n);
        check({v.name, " busy cycles"}, busy_n, v.busy_n);
        check({v.name, " line_buffer_reset cycles"}, lbr_n, v.lbr_n);
        check({v.name, " shifting_filter beats"}, sf_n, v.sf_n);
        check({v.name, " shifting_filter first"}, sf_f, v.sf_f);
        check({v.name, " shifting_filter last"}, sf_l, v.sf_l);
        check({v.name, " shifting_line beats"}, sl_n, v.sl_n);
        check({v.name, " shifting_line first"}, sl_f, v.sl_f);
        check({v.name, " mac beats"}, mac_n, v.mac_n);
        check({v.name, " mac first"}, mac_f, v.mac_f);
        check({v.name, " mac last"}, mac_l, v.mac_l);
        check({v.name, " adder beats"}, add_n, v.add_n);
        check({v.name, " nl beats"}, nl_n, v.nl_n);
        check({v.name, " strobes outside mask"}, outside, 0);
        check({v.name, " strobes on stall"}, stall_hits, 0);
    endtask

    initial begin
        //         name         k row rows msk   nl stall rst rep | done dn busy lbr sf sf_f sf_l sl sl_f mac mac_f mac_l add nl
        vecs[0]  = '{"nominal",  3, 4, 5, 8'hFF, 1, -1, -1, 0,   35, 1, 35, 1,  9, 2, 10, 20, 11, 12, 19, 30, 6, 6};
        vecs[1]  = '{"stall",    3, 4, 5, 8'hFF, 1, 22, -1, 0,   38, 1, 38, 1,  9, 2, 10, 20, 11, 12, 19, 33, 6, 6};
        vecs[2]  = '{"rows<k",   3, 4, 2, 8'hFF, 1, -1, -1, 0,    1, 1,  1, 0,  0, -1, -1, 0, -1,  0, -1, -1, 0, 0};
        vecs[3]  = '{"mask0F",   3, 4, 5, 8'h0F, 1, -1, -1, 0,   35, 1, 35, 1,  9, 2, 10, 20, 11, 12, 19, 30, 6, 6};
        vecs[4]  = '{"k1",       1, 4, 2, 8'hFF, 0, -1, -1, 0,   15, 1, 15, 1,  1, 2,  2,  8,  3,  8,  3, 10, 8, 0};
        vecs[5]  = '{"k0",       0, 4, 5, 8'hFF, 1, -1, -1, 0,    1, 1,  1, 0,  0, -1, -1, 0, -1,  0, -1, -1, 0, 0};
        vecs[6]  = '{"row0",     3, 0, 5, 8'hFF, 1, -1, -1, 0,    1, 1,  1, 0,  0, -1, -1, 0, -1,  0, -1, -1, 0, 0};
        vecs[7]  = '{"rst_mid",  3, 4, 5, 8'hFF, 1, -1, 25, 0,   -1, 0, 25, 1,  9, 2, 10, 15, 11,  7, 19, 25, 3, 3};
        vecs[8]  = '{"after_rst",3, 4, 5, 8'hFF, 1, -1, -1, 0,   35, 1, 35, 1,  9, 2, 10, 20, 11, 12, 19, 30, 6, 6};
        vecs[9]  = '{"repulse",  3, 4, 5, 8'hFF, 1, -1, -1, 1,   35, 1, 35, 1,  9, 2, 10, 20, 11, 12, 19, 30, 6, 6};
        vecs[10] = '{"k7",       7, 7, 7, 8'hFF, 1, -1, -1, 0,  104, 1, 104, 1, 49, 2, 50, 49, 51,  7, 93, 99, 1, 1};

        rst = 1'b1; start = 1'b0; in_valid = 1'b1; nl_en = 1'b0;
        row_len = '0; n_rows = '0; ksize = '0; mask = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset status", int'({in_ready, lbr, busy, done}), 0);
        check("reset strobes", int'(sf | sl | mac | add | nl), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("idle busy", int'(busy), 0);

        for (int i = 0; i < 11; i++) run_pass(vecs[i]);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
